// File: rtl/pop_data.sv
// pop_data: drains the UART RX FIFO and rebuilds 4-byte speed frames
// (0xAA header, HI, LO, CHK=HI^LO), then presents the 14-bit speed value.
//
// Ports:
//   clk        in   system clock
//   reset_n    in   asynchronous active-low reset
//   fifo_empty in   RX FIFO empty flag
//   fifo_data  in   RX FIFO head word (first-word-fall-through)
//   fifo_read  out  pop strobe, one cycle per consumed byte
//   speed      out  last valid speed value, held between frames
//   done       out  one-cycle pulse when speed is updated
//   frame_err  out  one-cycle pulse on checksum, format or timeout error
module pop_data #(
    parameter int                   DATA_SIZE   = 8,
    parameter int                   WIDTH_SPEED = 14,
    parameter logic [DATA_SIZE-1:0] HEADER      = 8'hAA,
    parameter int                   TIMEOUT_CYC = 50000,
    parameter int                   WIDTH_TO    = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   fifo_empty,
    input  logic [DATA_SIZE-1:0]   fifo_data,
    output logic                   fifo_read,
    output logic [WIDTH_SPEED-1:0] speed,
    output logic                   done,
    output logic                   frame_err
);

    localparam int HI_BITS = WIDTH_SPEED - DATA_SIZE;

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        HI   = 2'd1,
        LO   = 2'd2,
        CHK  = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [DATA_SIZE-1:0]   r_hi;
    logic [DATA_SIZE-1:0]   r_lo;
    logic [WIDTH_TO-1:0]    r_cnt;
    logic [WIDTH_SPEED-1:0] r_speed;
    logic                   r_done;
    logic                   r_err;

    logic [DATA_SIZE-1:0]   w_hi_nxt;
    logic [DATA_SIZE-1:0]   w_lo_nxt;
    logic [WIDTH_TO-1:0]    w_cnt_nxt;
    logic [WIDTH_SPEED-1:0] w_speed_nxt;
    logic                   w_done_nxt;
    logic                   w_err_nxt;

    logic                   w_pop;
    logic                   w_hi_bad;
    logic                   w_chk_ok;
    logic                   w_timeout;

    // The block never back-pressures: any available byte is consumed.
    assign w_pop     = ~fifo_empty & reset_n;
    assign w_hi_bad  = fifo_data[DATA_SIZE-1:HI_BITS] != '0;
    assign w_chk_ok  = fifo_data == (r_hi ^ r_lo);
    // A byte arriving on the limit cycle wins over the timeout.
    assign w_timeout = (r_state != HUNT) && !w_pop &&
                       (r_cnt == WIDTH_TO'(TIMEOUT_CYC - 1));

    assign fifo_read = w_pop;
    assign speed     = r_speed;
    assign done      = r_done;
    assign frame_err = r_err;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= HUNT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            HUNT: begin
                if (w_pop && fifo_data == HEADER) w_state_nxt = HI;
            end
            HI: begin
                if (w_pop)          w_state_nxt = w_hi_bad ? HUNT : LO;
                else if (w_timeout) w_state_nxt = HUNT;
            end
            LO: begin
                if (w_pop)          w_state_nxt = CHK;
                else if (w_timeout) w_state_nxt = HUNT;
            end
            CHK: begin
                if (w_pop || w_timeout) w_state_nxt = HUNT;
            end
            default: w_state_nxt = HUNT;
        endcase
    end

    always_comb begin
        w_done_nxt  = (r_state == CHK) && w_pop && w_chk_ok;
        w_err_nxt   = w_timeout ||
                      ((r_state == HI)  && w_pop && w_hi_bad) ||
                      ((r_state == CHK) && w_pop && !w_chk_ok);
        w_hi_nxt    = ((r_state == HI) && w_pop) ? fifo_data : r_hi;
        w_lo_nxt    = ((r_state == LO) && w_pop) ? fifo_data : r_lo;
        w_speed_nxt = w_done_nxt ? {r_hi[HI_BITS-1:0], r_lo} : r_speed;
        if (r_state == HUNT || w_pop || w_timeout) begin
            w_cnt_nxt = '0;
        end else begin
            w_cnt_nxt = r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hi    <= '0;
            r_lo    <= '0;
            r_cnt   <= '0;
            r_speed <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_hi    <= w_hi_nxt;
            r_lo    <= w_lo_nxt;
            r_cnt   <= w_cnt_nxt;
            r_speed <= w_speed_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
        end
    end

endmodule
